pipeline_if_fetch: RTL and testbench

PIPELINE_IF_FETCH -- requirements
Module: pipeline_if_fetch

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/pipeline_if_fetch_if.sv | 24 ++
 rtl/pipeline_if_fsm.sv | 124 ++++++++++++
 rtl/pipeline_if_fetch.sv | 111 +++++++++++
 tb/tb_pipeline_if_fetch.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble instruction,
// default reset PC and the fetch FSM state encoding.
package pipeline_pkg;

    // addi x0, x0, 0 -- the canonical bubble
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDiscard
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pipeline_if_fetch_if.sv
// Instruction-memory request/response bus used by the fetch stage.
// master: the fetch stage; slave: the instruction memory.
interface pipeline_if_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/pipeline_if_fsm.sv
// Fetch control FSM: tracks the outstanding memory request, owns the hold
// buffer used when an instruction returns while the pipeline is stalled, and
// decodes per-cycle strobes that tell the top how to update PC and IF/ID.
module pipeline_if_fsm
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcsrc,
    input  logic        stall,
    input  logic        ack,
    input  logic [31:0] rdata,
    output logic        req,
    output logic        discarding,
    output logic [31:0] hold_buf,
    output logic        redirect,
    output logic        start_discard,
    output logic        load_valid,
    output logic        load_bubble,
    output logic        use_buf
);

    fetch_state_e state;

    // Decode what this cycle does to PC and IF/ID; redirect outranks everything.
    always_comb begin
        redirect      = 1'b0;
        start_discard = 1'b0;
        load_valid    = 1'b0;
        load_bubble   = 1'b0;
        use_buf       = 1'b0;
        unique case (state)
            StIdle: begin
                // redirect and stall are ignored while idle
            end
            StFetch: begin
                if (pcsrc) begin
                    redirect      = 1'b1;
                    start_discard = ~ack;
                end else if (ack && !stall) begin
                    load_valid = 1'b1;
                end else if (!ack && !stall) begin
                    load_bubble = 1'b1;
                end
            end
            StHold: begin
                if (pcsrc) begin
                    redirect = 1'b1;
                end else if (!stall) begin
                    load_valid = 1'b1;
                    use_buf    = 1'b1;
                end
            end
            StDiscard: begin
                // Wrong-path data is never loaded; keep inserting bubbles.
                if (pcsrc) begin
                    redirect = 1'b1;
                end else if (!stall) begin
                    load_bubble = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // State register with registered request and discard flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            req        <= 1'b0;
            discarding <= 1'b0;
            hold_buf   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    state <= StFetch;
                    req   <= 1'b1;
                end
                StFetch: begin
                    if (pcsrc) begin
                        hold_buf <= '0;
                        if (ack) begin
                            state <= StFetch;
                        end else begin
                            // Request still in flight: wait for it and drop its data.
                            state      <= StDiscard;
                            discarding <= 1'b1;
                        end
                    end else if (ack && stall) begin
                        state    <= StHold;
                        req      <= 1'b0;
                        hold_buf <= rdata;
                    end
                end
                StHold: begin
                    if (pcsrc) begin
                        state    <= StFetch;
                        req      <= 1'b1;
                        hold_buf <= '0;
                    end else if (!stall) begin
                        state <= StFetch;
                        req   <= 1'b1;
                    end
                end
                StDiscard: begin
                    if (pcsrc) begin
                        hold_buf <= '0;
                    end
                    if (ack) begin
                        state      <= StFetch;
                        discarding <= 1'b0;
                    end
                end
                default: begin
                    state      <= StIdle;
                    req        <= 1'b0;
                    discarding <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_if_fetch.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and the
// instruction-memory request path. Control lives in pipeline_if_fsm.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt / redirect_cnt outputs.
module pipeline_if_fetch #(
    parameter logic [31:0] RESET_PC = pipeline_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = pipeline_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                PCSrc,
    input  logic [31:0]         target_in,
    input  logic                stall,
    pipeline_if_fetch_if.master imem,
    output logic [31:0]         PC_out_ID,
    output logic [31:0]         inst_out_ID,
    output logic                valid_out_ID,
    output logic                flush_ID_EX,
    output logic                flush_EX_MEM
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         redirect_cnt
`endif
);

    logic [31:0] pc_q;
    logic [31:0] old_addr_q;
    logic        req;
    logic        discarding;
    logic [31:0] hold_buf;
    logic        redirect;
    logic        start_discard;
    logic        load_valid;
    logic        load_bubble;
    logic        use_buf;

    pipeline_if_fsm u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcsrc         (PCSrc),
        .stall         (stall),
        .ack           (imem.ack),
        .rdata         (imem.rdata),
        .req           (req),
        .discarding    (discarding),
        .hold_buf      (hold_buf),
        .redirect      (redirect),
        .start_discard (start_discard),
        .load_valid    (load_valid),
        .load_bubble   (load_bubble),
        .use_buf       (use_buf)
    );

    // While discarding, the old address stays on the bus until its ack.
    assign imem.req  = req;
    assign imem.addr = discarding ? old_addr_q : pc_q;

    assign flush_ID_EX  = PCSrc;
    assign flush_EX_MEM = PCSrc;

    // PC update: redirect first, otherwise advance when an instruction is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            old_addr_q <= RESET_PC;
        end else begin
            if (start_discard) begin
                old_addr_q <= pc_q;
            end
            if (redirect) begin
                pc_q <= pipeline_pkg::align_word(target_in);
            end else if (load_valid) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    // IF/ID register: bubbles keep the previous PC, valid loads take PC and data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC_out_ID    <= '0;
            inst_out_ID  <= NOP_INST;
            valid_out_ID <= 1'b0;
        end else if (redirect || load_bubble) begin
            inst_out_ID  <= NOP_INST;
            valid_out_ID <= 1'b0;
        end else if (load_valid) begin
            PC_out_ID    <= pc_q;
            inst_out_ID  <= use_buf ? hold_buf : imem.rdata;
            valid_out_ID <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Event counters: valid instructions entering IF/ID and accepted redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (load_valid) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_if_fetch.sv
// Directed bench for pipeline_if_fetch with a zero-latency memory model whose
// ack can be withheld per cycle.
module tb_pipeline_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcsrc;
    logic        stall;
    logic        ack_en;
    logic [31:0] target;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;
    logic        fl_idex;
    logic        fl_exmem;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pipeline_if_fetch_if imem_bus ();

    pipeline_if_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrc        (pcsrc),
        .target_in    (target),
        .stall        (stall),
        .imem         (imem_bus),
        .PC_out_ID    (pc_id),
        .inst_out_ID  (inst_id),
        .valid_out_ID (valid_id),
        .flush_ID_EX  (fl_idex),
        .flush_EX_MEM (fl_exmem)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    assign imem_bus.ack   = imem_bus.req & ack_en;
    assign imem_bus.rdata = mem_word(imem_bus.addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idif(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic v);
        chk({tag, ".pc"}, pc_id, pc);
        chk({tag, ".inst"}, inst_id, inst);
        chk({tag, ".valid"}, {31'd0, valid_id}, {31'd0, v});
    endtask

    task automatic bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, imem_bus.req}, {31'd0, r});
        if (r) chk({tag, ".addr"}, imem_bus.addr, a);
    endtask

    initial begin
        rst_n = 1'b0; pcsrc = 1'b0; stall = 1'b0; ack_en = 1'b1; target = '0;
        tick(); tick();
        bus("rst", 1'b0, 32'h0);
        idif("rst", 32'h0, NOP, 1'b0);
        chk("rst.flush", {31'd0, fl_idex}, 32'd0);

        // One idle cycle, then back-to-back fetches with immediate ack
        rst_n = 1'b1; #1;
        bus("idle", 1'b0, 32'h0);
        tick();
        bus("f0", 1'b1, 32'h0);
        chk("f0.valid", {31'd0, valid_id}, 32'd0);
        tick(); idif("if0", 32'h0, mem_word(32'h0), 1'b1); bus("a4", 1'b1, 32'h4);
        tick(); idif("if4", 32'h4, mem_word(32'h4), 1'b1); bus("a8", 1'b1, 32'h8);
        tick(); idif("if8", 32'h8, mem_word(32'h8), 1'b1); bus("ac", 1'b1, 32'hC);
        tick(); idif("ifc", 32'hC, mem_word(32'hC), 1'b1); bus("a10", 1'b1, 32'h10);

        // Ack withheld two cycles at 0x10
        ack_en = 1'b0;
        tick(); idif("bub1", 32'hC, NOP, 1'b0); bus("a10h1", 1'b1, 32'h10);
        tick(); idif("bub2", 32'hC, NOP, 1'b0); bus("a10h2", 1'b1, 32'h10);
        ack_en = 1'b1;
        tick(); idif("if10", 32'h10, mem_word(32'h10), 1'b1); bus("a14", 1'b1, 32'h14);
        tick(); tick(); tick();
        idif("if1c", 32'h1C, mem_word(32'h1C), 1'b1); bus("a20", 1'b1, 32'h20);

        // Stall arriving with the ack at 0x20, held three cycles
        stall = 1'b1;
        tick(); bus("hold1", 1'b0, 32'h0); idif("hold1", 32'h1C, mem_word(32'h1C), 1'b1);
        tick(); bus("hold2", 1'b0, 32'h0);
        tick(); bus("hold3", 1'b0, 32'h0); idif("hold3", 32'h1C, mem_word(32'h1C), 1'b1);
        stall = 1'b0;
        tick(); idif("if20", 32'h20, mem_word(32'h20), 1'b1); bus("a24", 1'b1, 32'h24);
        tick(); tick(); tick();
        idif("if2c", 32'h2C, mem_word(32'h2C), 1'b1); bus("a30", 1'b1, 32'h30);

        // Redirect to 0x103 while the 0x30 request is pending
        ack_en = 1'b0; pcsrc = 1'b1; target = 32'h0000_0103; #1;
        chk("redir.flush_idex", {31'd0, fl_idex}, 32'd1);
        chk("redir.flush_exmem", {31'd0, fl_exmem}, 32'd1);
        tick(); idif("disc1", 32'h2C, NOP, 1'b0); bus("disc1", 1'b1, 32'h30);
        pcsrc = 1'b0; #1;
        chk("redir.flush_off", {31'd0, fl_idex}, 32'd0);
        tick(); bus("disc2", 1'b1, 32'h30);
        ack_en = 1'b1;
        tick(); idif("drop30", 32'h2C, NOP, 1'b0); bus("a100", 1'b1, 32'h100);
        tick(); idif("if100", 32'h100, mem_word(32'h100), 1'b1); bus("a104", 1'b1, 32'h104);

        // Redirect together with stall
        pcsrc = 1'b1; stall = 1'b1; target = 32'h0000_0200;
        tick(); idif("rs", 32'h100, NOP, 1'b0); bus("a200", 1'b1, 32'h200);
        pcsrc = 1'b0; stall = 1'b0;
        tick(); idif("if200", 32'h200, mem_word(32'h200), 1'b1);

        // PC wrap at the top of the address space
        pcsrc = 1'b1; target = 32'hFFFF_FFFF;
        tick(); bus("atop", 1'b1, 32'hFFFF_FFFC); chk("atop.valid", {31'd0, valid_id}, 32'd0);
        pcsrc = 1'b0;
        tick(); idif("iftop", 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1);
        bus("wrap", 1'b1, 32'h0);
        tick(); idif("ifwrap", 32'h0, mem_word(32'h0), 1'b1);
`ifdef IF_PERF_CNT_EN
        chk("cnt.fetch", fetch_cnt, 32'd16);
        chk("cnt.redirect", redirect_cnt, 32'd3);
`endif

        // Reset mid-request; redirect and stall ignored in the idle cycle
        rst_n = 1'b0;
        tick(); bus("rst2", 1'b0, 32'h0); idif("rst2", 32'h0, NOP, 1'b0);
        rst_n = 1'b1; pcsrc = 1'b1; stall = 1'b1; target = 32'h0000_0400;
        tick(); bus("idle_ign", 1'b1, 32'h0);
        pcsrc = 1'b0; stall = 1'b0;
        tick(); idif("if0b", 32'h0, mem_word(32'h0), 1'b1);

        // Redirect from HOLD drops the buffered instruction
        stall = 1'b1;
        tick(); bus("hold_b", 1'b0, 32'h0);
        pcsrc = 1'b1; target = 32'h0000_0300;
        tick(); idif("hold_redir", 32'h0, NOP, 1'b0); bus("a300", 1'b1, 32'h300);
        pcsrc = 1'b0; stall = 1'b0;
        tick(); idif("if300", 32'h300, mem_word(32'h300), 1'b1); bus("a304", 1'b1, 32'h304);
`ifdef IF_PERF_CNT_EN
        chk("cnt2.fetch", fetch_cnt, 32'd2);
        chk("cnt2.redirect", redirect_cnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
